multi_ce_driver: RTL and testbench

Multi-channel, runtime-programmable clock-enable generator. Produces `NUM_CH` independent single-cycle `ce` pulse trains from one system clock. Each channel has its own period and phase, and settings are reprogrammed glitch-free at period boundaries. A global `sync` re-aligns all channels. Sits between the system clock/reset tree and multirate datapath blocks (PID controller, filters, decimators) that need several enable rates with known phase relationships.

---
 rtl/multi_ce_driver.sv | 180 ++++++++++++++++++
 tb/tb_multi_ce_driver.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ce_driver.sv
// multi_ce_driver: multi-channel, runtime-programmable clock-enable generator.
// Each channel counts sysce-qualified cycles modulo its period and emits a
// single-cycle ce pulse when the count matches its phase, after a fixed
// pipeline delay. New period/phase settings wait in a shadow register and are
// loaded only at a period boundary, on sync, or while the channel is disabled,
// so a running pulse train never sees a partial period.
module multi_ce_driver #(
    parameter int NUM_CH         = 4,
    parameter int CNT_WIDTH      = 16,
    parameter int PIPELINE_REGS  = 2,
    parameter int DEFAULT_PERIOD = 2,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 sysclk,
    input  logic                 sysclr_n,
    input  logic                 sysce,
    input  logic                 sync,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_phase,
    output logic                 cfg_err,
    output logic [NUM_CH-1:0]    ce
);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t CntOne    = cnt_t'(1);
    localparam cnt_t PeriodRst = cnt_t'(DEFAULT_PERIOD);

    // Live per-channel state
    cnt_t cnt_q    [NUM_CH];
    cnt_t cnt_d    [NUM_CH];
    cnt_t period_q [NUM_CH];
    cnt_t period_d [NUM_CH];
    cnt_t phase_q  [NUM_CH];
    cnt_t phase_d  [NUM_CH];

    // Staged settings waiting for the next safe load point
    cnt_t shadow_period_q [NUM_CH];
    cnt_t shadow_period_d [NUM_CH];
    cnt_t shadow_phase_q  [NUM_CH];
    cnt_t shadow_phase_d  [NUM_CH];

    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] pending_d;
    logic              cfg_err_q;

    logic              cfg_bad;
    logic              cfg_xfer;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] apply_shadow;
    logic [NUM_CH-1:0] apply_direct;

    // Ready reflects the addressed channel only; out-of-range channels read as
    // ready so the request can complete and be rejected with cfg_err.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pending_q[i];
            end
        end
    end

    // Request validation and handshake
    always_comb begin
        cfg_bad  = (cfg_period == '0) || (cfg_phase >= cfg_period) ||
                   (32'(cfg_ch) >= 32'(NUM_CH));
        cfg_xfer = cfg_valid && cfg_ready && sysce;
    end

    // Per-channel decode: boundary detection, match, and load selection
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wrap[i]   = ch_enable[i] && (cnt_q[i] == period_q[i] - CntOne);
            hit[i]    = ch_enable[i] && (cnt_q[i] == phase_q[i]);
            accept[i] = cfg_xfer && !cfg_bad && (cfg_ch == CH_W'(i));
            // A request accepted together with sync bypasses the shadow stage.
            apply_direct[i] = sync && accept[i];
            apply_shadow[i] = sysce && pending_q[i] &&
                              (sync || !ch_enable[i] ||
                               (cnt_q[i] == period_q[i] - CntOne));
        end
    end

    // Next-state: counters, live settings, shadow registers, pending flags
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]           = cnt_q[i];
            period_d[i]        = period_q[i];
            phase_d[i]         = phase_q[i];
            shadow_period_d[i] = shadow_period_q[i];
            shadow_phase_d[i]  = shadow_phase_q[i];
            if (sysce) begin
                // sync outranks wrap, which outranks counting
                if (sync || !ch_enable[i] || wrap[i]) begin
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end

                if (apply_direct[i]) begin
                    period_d[i] = cfg_period;
                    phase_d[i]  = cfg_phase;
                end else if (apply_shadow[i]) begin
                    period_d[i]  = shadow_period_q[i];
                    phase_d[i]   = shadow_phase_q[i];
                    pending_d[i] = 1'b0;
                end

                // accept requires ready, so it never collides with apply_shadow
                if (accept[i] && !sync) begin
                    shadow_period_d[i] = cfg_period;
                    shadow_phase_d[i]  = cfg_phase;
                    pending_d[i]       = 1'b1;
                end
            end
        end
    end

    // State registers
    always_ff @(posedge sysclk or negedge sysclr_n) begin
        if (!sysclr_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]           <= '0;
                period_q[i]        <= PeriodRst;
                phase_q[i]         <= '0;
                shadow_period_q[i] <= PeriodRst;
                shadow_phase_q[i]  <= '0;
            end
            pending_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]           <= cnt_d[i];
                period_q[i]        <= period_d[i];
                phase_q[i]         <= phase_d[i];
                shadow_period_q[i] <= shadow_period_d[i];
                shadow_phase_q[i]  <= shadow_phase_d[i];
            end
            pending_q <= pending_d;
            cfg_err_q <= cfg_xfer && cfg_bad;
        end
    end

    assign cfg_err = cfg_err_q;

    // Hit pipeline; gating the output with sysce keeps ce confined to
    // qualified cycles even when a stage is holding during sysce low.
    generate
        if (PIPELINE_REGS == 0) begin : g_no_pipe
            assign ce = hit & {NUM_CH{sysce}};
        end else begin : g_pipe
            logic [NUM_CH-1:0] pipe_q [PIPELINE_REGS];

            // Shift hits forward on qualified cycles only
            always_ff @(posedge sysclk or negedge sysclr_n) begin
                if (!sysclr_n) begin
                    for (int s = 0; s < PIPELINE_REGS; s++) begin
                        pipe_q[s] <= '0;
                    end
                end else if (sysce) begin
                    pipe_q[0] <= hit;
                    for (int s = 1; s < PIPELINE_REGS; s++) begin
                        pipe_q[s] <= pipe_q[s-1];
                    end
                end
            end

            assign ce = pipe_q[PIPELINE_REGS-1] & {NUM_CH{sysce}};
        end
    endgenerate

endmodule

// File: tb/tb_multi_ce_driver.sv
// Self-checking bench for multi_ce_driver. The reference model tracks, per
// channel, the qualified-cycle index at which its current period started and
// derives the count by modular arithmetic; ce is the hit vector delayed in a
// queue of qualified cycles.
module tb_multi_ce_driver;

    localparam int NUM_CH    = 4;
    localparam int CNT_WIDTH = 16;
    localparam int PIPE      = 2;
    localparam int DEF_PER   = 2;
    localparam int CH_W      = 2;

    logic                 sysclk     = 1'b0;
    logic                 sysclr_n   = 1'b0;
    logic                 sysce      = 1'b1;
    logic                 sync       = 1'b0;
    logic [NUM_CH-1:0]    ch_enable  = '0;
    logic                 cfg_valid  = 1'b0;
    logic [CH_W-1:0]      cfg_ch     = '0;
    logic [CNT_WIDTH-1:0] cfg_period = '0;
    logic [CNT_WIDTH-1:0] cfg_phase  = '0;
    logic                 cfg_ready;
    logic                 cfg_err;
    logic [NUM_CH-1:0]    ce;

    int n_cmp = 0;
    int n_bad = 0;

    multi_ce_driver #(
        .NUM_CH         (NUM_CH),
        .CNT_WIDTH      (CNT_WIDTH),
        .PIPELINE_REGS  (PIPE),
        .DEFAULT_PERIOD (DEF_PER)
    ) dut (
        .sysclk     (sysclk),
        .sysclr_n   (sysclr_n),
        .sysce      (sysce),
        .sync       (sync),
        .ch_enable  (ch_enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_phase  (cfg_phase),
        .cfg_err    (cfg_err),
        .ce         (ce)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int                m_k;
    int                m_base   [NUM_CH];
    int                m_per    [NUM_CH];
    int                m_ph     [NUM_CH];
    bit                m_pend   [NUM_CH];
    int                m_sh_per [NUM_CH];
    int                m_sh_ph  [NUM_CH];
    logic [NUM_CH-1:0] m_hitq   [$];
    bit                m_err;
    logic [NUM_CH-1:0] exp_ce;
    logic [NUM_CH-1:0] exp_hit;
    logic              exp_ready;
    logic              exp_err;

    task automatic model_reset();
        m_k = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_base[i] = 0;
            m_per[i]  = DEF_PER;
            m_ph[i]   = 0;
            m_pend[i] = 1'b0;
        end
        m_hitq.delete();
        for (int s = 0; s < PIPE; s++) m_hitq.push_back('0);
        m_err = 1'b0;
    endtask

    task automatic model_eval();
        for (int i = 0; i < NUM_CH; i++)
            exp_hit[i] = ch_enable[i] && (((m_k - m_base[i]) % m_per[i]) == m_ph[i]);
        exp_ce    = sysce ? m_hitq[0] : '0;
        exp_ready = !m_pend[cfg_ch];
        exp_err   = m_err;
    endtask

    task automatic model_edge();
        bit xfer;
        bit bad;
        bit acc;
        int cp;
        int cf;
        int pos;
        model_eval();
        cp    = int'(cfg_period);
        cf    = int'(cfg_phase);
        bad   = (cp == 0) || (cf >= cp);
        xfer  = cfg_valid && exp_ready && sysce;
        m_err = xfer && bad;
        if (!sysce) return;
        m_hitq.push_back(exp_hit);
        void'(m_hitq.pop_front());
        for (int i = 0; i < NUM_CH; i++) begin
            acc = xfer && !bad && (int'(cfg_ch) == i);
            pos = (m_k - m_base[i]) % m_per[i];
            if (sync) begin
                m_base[i] = m_k + 1;
                if (acc) begin
                    m_per[i] = cp;
                    m_ph[i]  = cf;
                end else if (m_pend[i]) begin
                    m_per[i] = m_sh_per[i]; m_ph[i] = m_sh_ph[i]; m_pend[i] = 1'b0;
                end
            end else if (!ch_enable[i]) begin
                m_base[i] = m_k + 1;
                if (m_pend[i]) begin
                    m_per[i] = m_sh_per[i]; m_ph[i] = m_sh_ph[i]; m_pend[i] = 1'b0;
                end
            end else if ((pos == m_per[i] - 1) && m_pend[i]) begin
                m_base[i] = m_k + 1;
                m_per[i] = m_sh_per[i]; m_ph[i] = m_sh_ph[i]; m_pend[i] = 1'b0;
            end
            if (acc && !sync) begin
                m_sh_per[i] = cp;
                m_sh_ph[i]  = cf;
                m_pend[i]   = 1'b1;
            end
        end
        m_k++;
    endtask

    // ---------------- sequencing helpers (no checks) ----------------
    task automatic mid();
        @(negedge sysclk);
        model_eval();
    endtask

    task automatic adv();
        @(posedge sysclk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(posedge sysclk);
        #1;
        sysclr_n = 1'b0;
        model_reset();
        #2;
        sysclr_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sysclr_n = 1'b0;
        #2;
        n_cmp++; if (ce !== '0) begin n_bad++;
            $display("FAIL reset_ce: got %b expected 0000", ce); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++;
            $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_bad++;
            $display("FAIL reset_err: got %b expected 0", cfg_err); end
        @(posedge sysclk);
        #1;
        n_cmp++; if (ce !== '0) begin n_bad++;
            $display("FAIL reset_hold_ce: got %b expected 0000", ce); end
    endtask

    task automatic test_default();
        logic exp0;
        ch_enable = 4'b0001;
        sysce     = 1'b1;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            mid();
            exp0 = (c >= 2) && (c % 2 == 0);
            n_cmp++; if (ce !== exp_ce) begin n_bad++;
                $display("FAIL default_ce c=%0d: got %b expected %b", c, ce, exp_ce); end
            n_cmp++; if (ce[0] !== exp0 || ce[3:1] !== 3'b000) begin n_bad++;
                $display("FAIL default_pattern c=%0d: got %b expected ce0=%b", c, ce, exp0); end
            adv();
        end
    endtask

    task automatic test_reprogram();
        logic exp1;
        logic expr;
        ch_enable = 4'b0011;
        cfg_ch    = 2'd1;
        do_reset();
        for (int c = 0; c < 26; c++) begin
            if (c == 1) begin
                cfg_valid = 1'b1; cfg_period = 16'd5; cfg_phase = 16'd3;
            end else begin
                cfg_valid = 1'b0;
            end
            mid();
            exp1 = (c == 2) || (c == 4) || ((c >= 9) && ((c - 9) % 5 == 0));
            expr = !((c == 2) || (c == 3));
            n_cmp++; if (ce !== exp_ce) begin n_bad++;
                $display("FAIL reprog_ce c=%0d: got %b expected %b", c, ce, exp_ce); end
            n_cmp++; if (ce[1] !== exp1) begin n_bad++;
                $display("FAIL reprog_ch1 c=%0d: got %b expected %b", c, ce[1], exp1); end
            n_cmp++; if (cfg_ready !== expr || cfg_ready !== exp_ready) begin n_bad++;
                $display("FAIL reprog_ready c=%0d: got %b expected %b", c, cfg_ready, expr); end
            adv();
        end
    endtask

    task automatic test_reject();
        logic expe;
        cfg_ch = 2'd1;
        for (int j = 0; j < 12; j++) begin
            cfg_valid = (j == 0) || (j == 4);
            cfg_period = (j == 4) ? 16'd0 : 16'd4;
            cfg_phase  = (j == 4) ? 16'd0 : 16'd4;
            mid();
            expe = (j == 1) || (j == 5);
            n_cmp++; if (cfg_err !== expe || cfg_err !== exp_err) begin n_bad++;
                $display("FAIL reject_err j=%0d: got %b expected %b", j, cfg_err, expe); end
            n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++;
                $display("FAIL reject_ready j=%0d: got %b expected 1", j, cfg_ready); end
            n_cmp++; if (ce !== exp_ce) begin n_bad++;
                $display("FAIL reject_ce j=%0d: got %b expected %b", j, ce, exp_ce); end
            adv();
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_sysce_toggle();
        int   q;
        logic exp2;
        ch_enable = 4'b0000;
        sysce     = 1'b1;
        do_reset();
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_period = 16'd3; cfg_phase = 16'd0;
        adv();
        cfg_valid = 1'b0;
        adv();
        ch_enable = 4'b0100;
        q = 0;
        for (int j = 0; j < 24; j++) begin
            sysce = (j % 2 == 0);
            mid();
            exp2 = sysce && (q >= 2) && ((q - 2) % 3 == 0);
            n_cmp++; if (ce !== exp_ce) begin n_bad++;
                $display("FAIL toggle_ce j=%0d: got %b expected %b", j, ce, exp_ce); end
            n_cmp++; if (ce[2] !== exp2 || (!sysce && ce !== '0)) begin n_bad++;
                $display("FAIL toggle_ch2 j=%0d: got %b expected %b", j, ce[2], exp2); end
            adv();
            if (sysce) q++;
        end
        sysce = 1'b1;
    endtask

    task automatic test_sync();
        logic [NUM_CH-1:0] expv;
        ch_enable = 4'b0001;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            if (c == 3) ch_enable = 4'b1111;
            sync      = (c == 4);
            cfg_valid = (c == 4);
            cfg_ch    = 2'd3; cfg_period = 16'd3; cfg_phase = 16'd0;
            mid();
            case (c)
                5:       expv = 4'b1110;
                6:       expv = 4'b0001;
                7:       expv = 4'b1111;
                8:       expv = 4'b0000;
                9:       expv = 4'b0111;
                10:      expv = 4'b1000;
                default: expv = exp_ce;
            endcase
            n_cmp++; if (ce !== exp_ce || ce !== expv) begin n_bad++;
                $display("FAIL sync_ce c=%0d: got %b expected %b", c, ce, expv); end
            n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++;
                $display("FAIL sync_ready c=%0d: got %b expected 1", c, cfg_ready); end
            adv();
        end
        sync = 1'b0; cfg_valid = 1'b0;
    endtask

    task automatic test_random();
        ch_enable = 4'($urandom_range(0, 15));
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            sysce = ($urandom_range(0, 3) != 0);
            sync  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) ch_enable = 4'($urandom_range(0, 15));
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_period = 16'($urandom_range(0, 6));
            cfg_phase  = 16'($urandom_range(0, 6));
            mid();
            n_cmp++; if (ce !== exp_ce) begin n_bad++;
                $display("FAIL rand_ce c=%0d: got %b expected %b", c, ce, exp_ce); end
            n_cmp++; if (cfg_ready !== exp_ready) begin n_bad++;
                $display("FAIL rand_ready c=%0d: got %b expected %b", c, cfg_ready, exp_ready); end
            n_cmp++; if (cfg_err !== exp_err) begin n_bad++;
                $display("FAIL rand_err c=%0d: got %b expected %b", c, cfg_err, exp_err); end
            adv();
        end
        sysce = 1'b1; sync = 1'b0; cfg_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        logic exp0;
        ch_enable = 4'b0001;
        do_reset();
        adv();
        adv();
        mid();
        n_cmp++; if (ce !== 4'b0001 || exp_ce !== 4'b0001) begin n_bad++;
            $display("FAIL arst_pre c=2: got %b expected 0001", ce); end
        sysclr_n = 1'b0;
        #1;
        n_cmp++; if (ce !== '0) begin n_bad++;
            $display("FAIL arst_immediate: got %b expected 0000", ce); end
        n_cmp++; if (cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin n_bad++;
            $display("FAIL arst_cfg: got ready=%b err=%b expected 1/0", cfg_ready, cfg_err); end
        model_reset();
        #1;
        sysclr_n = 1'b1;
        adv();
        for (int c = 1; c < 10; c++) begin
            mid();
            exp0 = (c >= 2) && (c % 2 == 0);
            n_cmp++; if (ce !== exp_ce || ce[0] !== exp0) begin n_bad++;
                $display("FAIL arst_after c=%0d: got %b expected ce0=%b", c, ce, exp0); end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_reprogram();
        test_reject();
        test_sysce_toggle();
        test_sync();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
